// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO that buffers SDRAM read/write bursts. It supports a normal mode and a
// show-ahead mode, programmable almost-full/almost-empty thresholds and sticky error flags.
module sdram_sync_fifo #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR      = 10,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned AFULL_TH  = (1 << ADDR) - 8,
  parameter int unsigned AEMPTY_TH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    usedw,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned   DEPTH    = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_W  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AFULL_W  = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0] AEMPTY_W = (ADDR+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wptr;
  logic [ADDR-1:0]  rptr;
  logic [ADDR-1:0]  rptr_nxt;
  logic [ADDR:0]    usedw_nxt;
  logic             rd_acc;
  logic             wr_acc;
  logic             wr_en;
  logic [WIDTH-1:0] head_nxt;

  always_comb begin
    rd_acc    = rdreq & ~empty;
    wr_acc    = wrreq & (~full | rd_acc);
    wr_en     = wr_acc & ~sclr;
    usedw_nxt = usedw + (ADDR+1)'(wr_acc) - (ADDR+1)'(rd_acc);
    rptr_nxt  = rptr + ADDR'(rd_acc);
    // When the incoming word will be the only one stored, it is the next head.
    // The memory write has not landed yet, so take it straight from the data input.
    head_nxt  = (wr_acc && usedw_nxt == (ADDR+1)'(1)) ? data : mem[rptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      q            <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      ovf          <= 1'b0;
      udf          <= 1'b0;
    end else if (sclr) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      q            <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      ovf          <= 1'b0;
      udf          <= 1'b0;
    end else begin
      wptr         <= wptr + ADDR'(wr_acc);
      rptr         <= rptr_nxt;
      usedw        <= usedw_nxt;
      empty        <= (usedw_nxt == '0);
      full         <= (usedw_nxt == DEPTH_W);
      almost_empty <= (usedw_nxt <= AEMPTY_W);
      almost_full  <= (usedw_nxt >= AFULL_W);
      if (wrreq && full && !rd_acc) ovf <= 1'b1;
      if (rdreq && empty)           udf <= 1'b1;
      if (SHOWAHEAD != 0) begin
        // Show-ahead: q tracks the head word and keeps the last value once drained.
        if (usedw_nxt != '0) q <= head_nxt;
      end else if (rd_acc) begin
        q <= mem[rptr];
      end
    end
  end

endmodule
